// File: rtl/ble_tx_framer.sv
// BLE link-layer transmit framer: serialises preamble, access address, PDU and
// the downstream CRC onto a single air bit, paced by an external symbol strobe.
module ble_tx_framer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] aa,
    input  logic [7:0]  pdu_len,
    input  logic [7:0]  data_in,
    input  logic        data_valid,
    output logic        data_ready,
    input  logic        bit_en,
    output logic        bit_out,
    output logic        bit_valid,
    output logic        crc_init,
    output logic        crc_en,
    output logic        crc_din,
    input  logic        crc_msb,
    output logic        busy,
    output logic        done,
    output logic        underrun
);

    localparam int unsigned AA_W  = 32;
    localparam int unsigned LEN_W = 8;
    localparam int unsigned CNT_W = 5;

    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(7);
    localparam logic [CNT_W-1:0] AA_LAST   = CNT_W'(31);
    localparam logic [CNT_W-1:0] BYTE_LAST = CNT_W'(7);
    localparam logic [CNT_W-1:0] CRC_LAST  = CNT_W'(23);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_AA,
        S_PDU,
        S_CRC
    } state_e;

    state_e             state_q;
    logic [AA_W-1:0]    sh_q;
    logic [AA_W-1:0]    aa_q;
    logic [7:0]         buf_q;
    logic               buf_full_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   fetched_q;
    logic [LEN_W-1:0]   byte_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic               done_q;
    logic               underrun_q;

    logic accept;
    logic fetch;
    logic last_byte;
    logic need_load;
    logic starve;

    assign accept    = (state_q == S_IDLE) && start && (pdu_len != '0);
    assign fetch     = data_ready && data_valid;
    assign last_byte = (byte_q == len_q - LEN_W'(1));
    // A byte boundary that must pull the prefetch buffer into the shifter
    assign need_load = bit_en &&
                       (((state_q == S_AA)  && (cnt_q == AA_LAST)) ||
                        ((state_q == S_PDU) && (cnt_q == BYTE_LAST) && !last_byte));
    assign starve    = need_load && !buf_full_q;

    assign crc_init   = rst_n && accept;
    assign data_ready = !buf_full_q && (state_q inside {S_PRE, S_AA, S_PDU}) &&
                        (fetched_q < len_q);
    assign crc_en     = bit_en && ((state_q == S_PDU) || (state_q == S_CRC)) && !starve;

    always_comb begin
        crc_din = 1'b0;
        case (state_q)
            S_PDU:   crc_din = sh_q[0];
            S_CRC:   crc_din = crc_msb;
            default: crc_din = 1'b0;
        endcase
    end

    // CRC bits come straight from the downstream register so they track its shifts
    assign bit_out   = (state_q == S_CRC) ? crc_msb : sh_q[0];
    assign bit_valid = busy_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign underrun  = underrun_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            sh_q       <= '0;
            aa_q       <= '0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            len_q      <= '0;
            fetched_q  <= '0;
            byte_q     <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            underrun_q <= 1'b0;

            if (fetch) begin
                buf_q      <= data_in;
                buf_full_q <= 1'b1;
                fetched_q  <= fetched_q + LEN_W'(1);
            end

            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        aa_q       <= aa;
                        len_q      <= pdu_len;
                        sh_q       <= {24'b0, (aa[0] ? 8'h55 : 8'hAA)};
                        cnt_q      <= '0;
                        fetched_q  <= '0;
                        byte_q     <= '0;
                        buf_full_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= S_PRE;
                    end
                end

                S_PRE: begin
                    if (bit_en) begin
                        if (cnt_q == PRE_LAST) begin
                            sh_q    <= aa_q;
                            cnt_q   <= '0;
                            state_q <= S_AA;
                        end else begin
                            sh_q  <= sh_q >> 1;
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end

                S_AA, S_PDU: begin
                    if (bit_en) begin
                        if (starve) begin
                            underrun_q <= 1'b1;
                            busy_q     <= 1'b0;
                            sh_q       <= '0;
                            cnt_q      <= '0;
                            buf_full_q <= 1'b0;
                            state_q    <= S_IDLE;
                        end else if (need_load) begin
                            sh_q       <= {24'b0, buf_q};
                            buf_full_q <= 1'b0;
                            cnt_q      <= '0;
                            byte_q     <= (state_q == S_AA) ? '0 : byte_q + LEN_W'(1);
                            state_q    <= S_PDU;
                        end else if ((state_q == S_PDU) && (cnt_q == BYTE_LAST)) begin
                            sh_q    <= '0;
                            cnt_q   <= '0;
                            state_q <= S_CRC;
                        end else begin
                            sh_q  <= sh_q >> 1;
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end

                S_CRC: begin
                    if (bit_en) begin
                        if (cnt_q == CRC_LAST) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            cnt_q   <= '0;
                            state_q <= S_IDLE;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ble_tx_framer.sv
// Bench for ble_tx_framer: hosts a CRC-24 register as the downstream peer and
// compares the air bit stream with a frame model built from the protocol rules.
module tb_ble_tx_framer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] aa;
    logic [7:0]  pdu_len;
    logic [7:0]  data_in;
    logic        data_valid;
    logic        data_ready;
    logic        bit_en;
    logic        bit_out;
    logic        bit_valid;
    logic        crc_init;
    logic        crc_en;
    logic        crc_din;
    logic        crc_msb;
    logic        busy;
    logic        done;
    logic        underrun;

    logic [23:0] crc_reg;

    int total = 0;
    int bad   = 0;

    logic [7:0] pdu_mem [256];
    logic       exp_q [$];
    logic       got_q [$];

    int   r_init, r_done, r_under, r_ur_bits, r_busy_cyc;
    int   r_hold_err, r_proto_err, r_crcen_lo, r_timeout, r_rst_pulse;
    logic [7:0] r_ab;

    always #5 clk = ~clk;

    ble_tx_framer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .aa         (aa),
        .pdu_len    (pdu_len),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .bit_en     (bit_en),
        .bit_out    (bit_out),
        .bit_valid  (bit_valid),
        .crc_init   (crc_init),
        .crc_en     (crc_en),
        .crc_din    (crc_din),
        .crc_msb    (crc_msb),
        .busy       (busy),
        .done       (done),
        .underrun   (underrun)
    );

    // Downstream BLE CRC-24 register (poly 0x00065B)
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)        crc_reg <= 24'h0;
        else if (crc_init) crc_reg <= 24'h555555;
        else if (crc_en)   crc_reg <= {crc_reg[22:0], 1'b0} ^
                                      ((crc_reg[23] ^ crc_din) ? 24'h00065B : 24'h0);
    end
    assign crc_msb = crc_reg[23];

    // Expected air bits: preamble, AA LSB first, PDU LSB first, CRC MSB first
    function automatic void build_expected(input logic [31:0] a, input int len);
        logic [23:0] c;
        logic [7:0]  pre;
        logic        b;
        exp_q.delete();
        pre = a[0] ? 8'h55 : 8'hAA;
        for (int i = 0; i < 8; i++)  exp_q.push_back(pre[i]);
        for (int i = 0; i < 32; i++) exp_q.push_back(a[i]);
        c = 24'h555555;
        for (int k = 0; k < len; k++) begin
            for (int i = 0; i < 8; i++) begin
                b = pdu_mem[k][i];
                exp_q.push_back(b);
                c = {c[22:0], 1'b0} ^ ((c[23] ^ b) ? 24'h00065B : 24'h0);
            end
        end
        for (int i = 23; i >= 0; i--) exp_q.push_back(c[i]);
    endfunction

    function automatic int count_diff(input int n);
        int d;
        d = 0;
        for (int i = 0; i < n; i++) begin
            if (i >= got_q.size() || i >= exp_q.size() || got_q[i] !== exp_q[i]) d++;
        end
        return d;
    endfunction

    // Drives one frame and records what the DUT did; abort_bit >= 0 asserts reset there
    task automatic run_frame(input logic [31:0] a, input int len, input int period,
                             input int avail, input int glitch_cyc, input int abort_bit);
        int   idx;
        int   cyc;
        logic prev_busy, prev_en, prev_bit, fin;
        idx = 0; cyc = 0; prev_busy = 0; prev_en = 0; prev_bit = 0; fin = 0;
        got_q.delete();
        r_init = 0; r_done = 0; r_under = 0; r_ur_bits = -1; r_busy_cyc = 0;
        r_hold_err = 0; r_proto_err = 0; r_crcen_lo = 0; r_timeout = 0;
        r_rst_pulse = 0; r_ab = 8'hFF;
        @(negedge clk);
        start = 1'b1; aa = a; pdu_len = 8'(len); bit_en = 1'b0; data_valid = 1'b0;
        #1 if (crc_init) r_init++;
        while (!fin) begin
            cyc++;
            @(negedge clk);
            start      = (cyc == glitch_cyc);
            pdu_len    = (cyc == glitch_cyc) ? 8'd5 : 8'(len);
            aa         = (cyc == glitch_cyc) ? ~a : a;
            bit_en     = ((cyc % period) == 0);
            data_valid = (idx < avail);
            data_in    = pdu_mem[idx[7:0]];
            if (abort_bit >= 0 && got_q.size() == abort_bit) begin
                rst_n  = 1'b0;
                bit_en = 1'b1;
                #1 r_ab = {busy, bit_valid, crc_en, bit_out, crc_init, data_ready, done, underrun};
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    #1 if (done || underrun || busy) r_rst_pulse++;
                end
                fin = 1'b1;
            end else begin
                #1;
                if (crc_init) r_init++;
                if (done) r_done++;
                if (underrun) begin
                    r_under++;
                    r_ur_bits = got_q.size();
                end
                if (busy) r_busy_cyc++;
                if (prev_busy && busy && !prev_en && (bit_out !== prev_bit)) r_hold_err++;
                if (crc_en && !bit_en) r_proto_err++;
                if (bit_en && busy) begin
                    got_q.push_back(bit_out);
                    if (got_q.size() <= 40) begin
                        if (crc_en) r_proto_err++;
                    end else begin
                        if (!crc_en) r_crcen_lo++;
                        if (got_q.size() <= 40 + 8 * len && crc_din !== bit_out) r_proto_err++;
                    end
                end
                if (data_ready && data_valid) idx++;
                prev_busy = busy; prev_en = bit_en; prev_bit = bit_out;
                if (cyc >= 2 && !busy) fin = 1'b1;
                if (cyc >= 4000) begin
                    r_timeout = 1;
                    fin = 1'b1;
                end
            end
        end
        start = 1'b0; bit_en = 1'b0; data_valid = 1'b0;
        if (abort_bit < 0) begin
            @(negedge clk);
            #1;
            if (done) r_done++;
            if (underrun) r_under++;
        end
    endtask

    task automatic load_ref();
        pdu_mem[0] = 8'h40;
        pdu_mem[1] = 8'h00;
        build_expected(32'h8E89BED6, 2);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; pdu_len = 8'd5; aa = 32'h12345679;
        data_valid = 1'b1; bit_en = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if ({busy, bit_valid, bit_out, crc_init, crc_en, data_ready, done, underrun} !== 8'h00) begin
            bad++;
            $display("FAIL reset_outputs got=%b want=00000000",
                     {busy, bit_valid, bit_out, crc_init, crc_en, data_ready, done, underrun});
        end
        @(negedge clk);
        rst_n = 1'b1; start = 1'b0; data_valid = 1'b0; bit_en = 1'b0;
        @(negedge clk);
        #1;
        total++;
        if ({busy, done, underrun, bit_out} !== 4'h0) begin
            bad++;
            $display("FAIL reset_release_idle got=%b want=0000", {busy, done, underrun, bit_out});
        end
    endtask

    task automatic test_ref_frame();
        logic [7:0] pre_got;
        load_ref();
        run_frame(32'h8E89BED6, 2, 4, 2, -1, -1);
        pre_got = '0;
        for (int i = 0; i < 8 && i < got_q.size(); i++) pre_got[i] = got_q[i];
        total++;
        if (got_q.size() !== 80) begin
            bad++; $display("FAIL ref_bitcount got=%0d want=80", got_q.size());
        end
        total++;
        if (pre_got !== 8'hAA) begin
            bad++; $display("FAIL ref_preamble got=%h want=aa (0,1,0,1.. lsb first)", pre_got);
        end
        total++;
        if (count_diff(80) !== 0) begin
            bad++; $display("FAIL ref_bits got_diffs=%0d want=0", count_diff(80));
        end
        total++;
        if (r_done !== 1 || r_under !== 0 || r_init !== 1) begin
            bad++; $display("FAIL ref_pulses got done=%0d under=%0d init=%0d want 1/0/1",
                            r_done, r_under, r_init);
        end
        total++;
        if (r_hold_err !== 0 || r_proto_err !== 0 || r_crcen_lo !== 0 || r_timeout !== 0) begin
            bad++; $display("FAIL ref_protocol got hold=%0d proto=%0d crcen_lo=%0d to=%0d want all 0",
                            r_hold_err, r_proto_err, r_crcen_lo, r_timeout);
        end
    endtask

    task automatic test_back_to_back();
        load_ref();
        run_frame(32'h8E89BED6, 2, 1, 2, -1, -1);
        total++;
        if (got_q.size() !== 80 || r_busy_cyc !== 80) begin
            bad++; $display("FAIL b2b_length got bits=%0d busy=%0d want 80/80", got_q.size(), r_busy_cyc);
        end
        total++;
        if (count_diff(80) !== 0) begin
            bad++; $display("FAIL b2b_bits got_diffs=%0d want=0", count_diff(80));
        end
        total++;
        if (r_under !== 0 || r_done !== 1) begin
            bad++; $display("FAIL b2b_pulses got under=%0d done=%0d want 0/1", r_under, r_done);
        end
    endtask

    task automatic test_underrun();
        pdu_mem[0] = 8'hC3; pdu_mem[1] = 8'h5A; pdu_mem[2] = 8'h0F;
        build_expected(32'h8E89BED6, 3);
        run_frame(32'h8E89BED6, 3, 4, 1, -1, -1);
        total++;
        if (r_under !== 1 || r_ur_bits !== 48) begin
            bad++; $display("FAIL underrun_pulse got count=%0d at_bit=%0d want 1 at 48", r_under, r_ur_bits);
        end
        total++;
        if (r_crcen_lo !== 1 || r_done !== 0 || busy !== 1'b0) begin
            bad++; $display("FAIL underrun_side got crcen_lo=%0d done=%0d busy=%b want 1/0/0",
                            r_crcen_lo, r_done, busy);
        end
        total++;
        if (count_diff(got_q.size()) !== 0) begin
            bad++; $display("FAIL underrun_prefix got_diffs=%0d want=0", count_diff(got_q.size()));
        end
    endtask

    task automatic test_ignored_start();
        int inits, busies;
        inits = 0; busies = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            start = 1'b1; pdu_len = 8'd0; aa = 32'hDEADBEEF;
            #1 if (crc_init) inits++;
        end
        @(negedge clk);
        start = 1'b0;
        #1 if (busy) busies++;
        total++;
        if (inits !== 0 || busies !== 0) begin
            bad++; $display("FAIL zero_len_start got init=%0d busy=%0d want 0/0", inits, busies);
        end
        load_ref();
        run_frame(32'h8E89BED6, 2, 4, 2, 30, -1);
        total++;
        if (r_init !== 1 || got_q.size() !== 80 || count_diff(80) !== 0 || r_done !== 1) begin
            bad++; $display("FAIL midframe_start got init=%0d bits=%0d diffs=%0d done=%0d want 1/80/0/1",
                            r_init, got_q.size(), count_diff(80), r_done);
        end
    endtask

    task automatic test_reset_mid_crc();
        load_ref();
        run_frame(32'h8E89BED6, 2, 4, 2, -1, 60);
        total++;
        if (r_ab !== 8'h00) begin
            bad++; $display("FAIL rst_crc_outputs got=%b want=00000000", r_ab);
        end
        total++;
        if (r_rst_pulse !== 0 || got_q.size() !== 60) begin
            bad++; $display("FAIL rst_crc_quiet got pulses=%0d bits=%0d want 0/60", r_rst_pulse, got_q.size());
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_frame(32'h8E89BED6, 2, 4, 2, -1, -1);
        total++;
        if (got_q.size() !== 80 || count_diff(80) !== 0 || r_done !== 1 || r_init !== 1) begin
            bad++; $display("FAIL rst_crc_restart got bits=%0d diffs=%0d done=%0d init=%0d want 80/0/1/1",
                            got_q.size(), count_diff(80), r_done, r_init);
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        int len, per, avail, nbits, lo_want;
        for (int it = 0; it < 8; it++) begin
            a   = $urandom;
            len = int'($urandom_range(1, 6));
            per = int'($urandom_range(1, 5));
            for (int k = 0; k < len; k++) pdu_mem[k] = 8'($urandom);
            avail = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, len - 1)) : len;
            build_expected(a, len);
            run_frame(a, len, per, avail, -1, -1);
            nbits   = (avail == len) ? 64 + 8 * len : 40 + 8 * avail;
            lo_want = (avail < len && avail > 0) ? 1 : 0;
            total++;
            if (got_q.size() !== nbits || count_diff(nbits) !== 0) begin
                bad++; $display("FAIL rand%0d_bits got n=%0d diffs=%0d want n=%0d diffs=0 (aa=%h len=%0d avail=%0d)",
                                it, got_q.size(), count_diff(nbits), nbits, a, len, avail);
            end
            total++;
            if (r_done !== ((avail == len) ? 1 : 0) || r_under !== ((avail == len) ? 0 : 1)) begin
                bad++; $display("FAIL rand%0d_pulses got done=%0d under=%0d avail=%0d len=%0d",
                                it, r_done, r_under, avail, len);
            end
            total++;
            if (r_hold_err !== 0 || r_proto_err !== 0 || r_crcen_lo !== lo_want || r_timeout !== 0) begin
                bad++; $display("FAIL rand%0d_protocol got hold=%0d proto=%0d crcen_lo=%0d to=%0d want 0/0/%0d/0",
                                it, r_hold_err, r_proto_err, r_crcen_lo, r_timeout, lo_want);
            end
            repeat (2) @(negedge clk);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; aa = '0; pdu_len = '0;
        data_in = '0; data_valid = 1'b0; bit_en = 1'b0;
        test_reset();
        test_ref_frame();
        test_back_to_back();
        test_underrun();
        test_ignored_start();
        test_reset_mid_crc();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
